// File: rtl/dual_bank_regfile_if.sv
// rtl/dual_bank_regfile_if.sv - read/write bus bundle for the dual-bank register file
//
// Purpose: groups the read specifiers, read buses, and write/transfer controls of
// dual_bank_regfile. clk and reset stay plain ports on the register file.
//
// Signals:
//   rs1, rs2, frs1, frs2   read specifiers (integer A/B, FP A/B)
//   busA, busB             integer read data
//   fbusA, fbusB           FP read data
//   rd, regWr, wrData      integer write port
//   frd, fregWr, fwrData   FP write port
//   xferWr, xferDir        cross-bank move (0: R[rs1] -> F[frd], 1: F[frs1] -> R[rd])
//
// Modports: master drives specifiers and writes, slave is the register file.

interface dual_bank_regfile_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
);
    logic [DEPTH_LOG2-1:0] rs1;
    logic [DEPTH_LOG2-1:0] rs2;
    logic [WIDTH-1:0]      busA;
    logic [WIDTH-1:0]      busB;
    logic [DEPTH_LOG2-1:0] frs1;
    logic [DEPTH_LOG2-1:0] frs2;
    logic [WIDTH-1:0]      fbusA;
    logic [WIDTH-1:0]      fbusB;
    logic [DEPTH_LOG2-1:0] rd;
    logic                  regWr;
    logic [WIDTH-1:0]      wrData;
    logic [DEPTH_LOG2-1:0] frd;
    logic                  fregWr;
    logic [WIDTH-1:0]      fwrData;
    logic                  xferWr;
    logic                  xferDir;

    modport master (
        output rs1, rs2, frs1, frs2,
        output rd, regWr, wrData,
        output frd, fregWr, fwrData,
        output xferWr, xferDir,
        input  busA, busB, fbusA, fbusB
    );

    modport slave (
        input  rs1, rs2, frs1, frs2,
        input  rd, regWr, wrData,
        input  frd, fregWr, fwrData,
        input  xferWr, xferDir,
        output busA, busB, fbusA, fbusB
    );
endinterface

// File: rtl/dual_bank_regfile.sv
// rtl/dual_bank_regfile.sv - integer + FP register file with cross-bank moves
//
// Purpose: two banks of 2**DEPTH_LOG2 x WIDTH registers. Four combinational read
// ports (busA/busB integer, fbusA/fbusB FP), one sequential write per bank, and a
// cross-bank move (movi2fp / movfp2i) that takes priority over the normal write
// into its destination bank. Integer r0 reads as zero and ignores writes.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; loads RESET_VAL everywhere except r0
//   bus    dual_bank_regfile_if.slave (specifiers, read buses, write controls)
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to
// any read port whose specifier matches the pending write target. Without it,
// reads always show the stored contents.

module dual_bank_regfile #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH_LOG2 = 5,
    parameter logic [WIDTH-1:0] RESET_VAL  = 32'h0000_0000
) (
    input logic                clk,
    input logic                reset,
    dual_bank_regfile_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_q [DEPTH];
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [WIDTH-1:0] f_q [DEPTH];
    logic [WIDTH-1:0] f_d [DEPTH];

    logic [DEPTH_LOG2-1:0] rs1_i, rs2_i, frs1_i, frs2_i, rd_i, frd_i;
    logic                  regWr_i, fregWr_i, xferWr_i, xferDir_i;
    logic [WIDTH-1:0]      wrData_i, fwrData_i;

    assign rs1_i     = bus.rs1;
    assign rs2_i     = bus.rs2;
    assign frs1_i    = bus.frs1;
    assign frs2_i    = bus.frs2;
    assign rd_i      = bus.rd;
    assign frd_i     = bus.frd;
    assign regWr_i   = bus.regWr;
    assign fregWr_i  = bus.fregWr;
    assign xferWr_i  = bus.xferWr;
    assign xferDir_i = bus.xferDir;
    assign wrData_i  = bus.wrData;
    assign fwrData_i = bus.fwrData;

    // Both the normal write and the move into a bank share that bank's write
    // specifier, so the move only has to win on the data mux.
    logic             xfer_to_int, xfer_to_fp;
    logic             int_we, fp_we;
    logic [WIDTH-1:0] int_wdata, fp_wdata;

    assign xfer_to_int = xferWr_i &&  xferDir_i;
    assign xfer_to_fp  = xferWr_i && !xferDir_i;

    assign int_we    = (regWr_i || xfer_to_int) && (rd_i != '0);
    assign int_wdata = xfer_to_int ? f_q[frs1_i] : wrData_i;
    assign fp_we     = fregWr_i || xfer_to_fp;
    // r_q[0] is held at zero, so a movi2fp from r0 moves zero.
    assign fp_wdata  = xfer_to_fp ? r_q[rs1_i] : fwrData_i;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            r_d[i] = r_q[i];
            f_d[i] = f_q[i];
        end
        if (int_we) begin
            r_d[rd_i] = int_wdata;
        end
        if (fp_we) begin
            f_d[frd_i] = fp_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= (i == 0) ? '0 : RESET_VAL;
                f_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= r_d[i];
                f_q[i] <= f_d[i];
            end
        end
    end

    logic [WIDTH-1:0] busA_o, busB_o, fbusA_o, fbusB_o;

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated off during reset so the pending (discarded) write never
    // becomes visible. int_we already excludes rd=0, and r0 is forced below anyway.
    logic int_byp_en, fp_byp_en;
    assign int_byp_en = int_we && !reset;
    assign fp_byp_en  = fp_we  && !reset;

    assign busA_o  = (rs1_i == '0) ? '0 :
                     (int_byp_en && rs1_i == rd_i) ? int_wdata : r_q[rs1_i];
    assign busB_o  = (rs2_i == '0) ? '0 :
                     (int_byp_en && rs2_i == rd_i) ? int_wdata : r_q[rs2_i];
    assign fbusA_o = (fp_byp_en && frs1_i == frd_i) ? fp_wdata : f_q[frs1_i];
    assign fbusB_o = (fp_byp_en && frs2_i == frd_i) ? fp_wdata : f_q[frs2_i];
`else
    assign busA_o  = (rs1_i == '0) ? '0 : r_q[rs1_i];
    assign busB_o  = (rs2_i == '0) ? '0 : r_q[rs2_i];
    assign fbusA_o = f_q[frs1_i];
    assign fbusB_o = f_q[frs2_i];
`endif

    assign bus.busA  = busA_o;
    assign bus.busB  = busB_o;
    assign bus.fbusA = fbusA_o;
    assign bus.fbusB = fbusB_o;
endmodule

// File: doc/dual_bank_regfile.md
Name: dual_bank_regfile

Overview:
- Integer and floating-point register file for the single-cycle datapath.
- Sits directly upstream of the ALU/FPU stage and drives busA/busB (integer) and fbusA/fbusB (FP) from instruction register specifiers.
- Writeback data (ALU result, FPU result, load data) returns here and is committed on the clock edge.
- Reads are combinational; writes are sequential.

Parameters:
- WIDTH, 32, data width of every register and bus.
- DEPTH_LOG2, 5, register specifier width; each bank holds 2**DEPTH_LOG2 registers.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- rs1  input  DEPTH_LOG2  integer read specifier A.
- rs2  input  DEPTH_LOG2  integer read specifier B.
- busA  output  WIDTH  integer read data A, feeds ALU busA.
- busB  output  WIDTH  integer read data B, feeds ALU busB.
- frs1  input  DEPTH_LOG2  FP read specifier A.
- frs2  input  DEPTH_LOG2  FP read specifier B.
- fbusA  output  WIDTH  FP read data A, feeds FPU fbusA.
- fbusB  output  WIDTH  FP read data B, feeds FPU fbusB.
- rd  input  DEPTH_LOG2  integer write specifier.
- regWr  input  1  integer write enable.
- wrData  input  WIDTH  integer write data.
- frd  input  DEPTH_LOG2  FP write specifier.
- fregWr  input  1  FP write enable.
- fwrData  input  WIDTH  FP write data.
- xferWr  input  1  cross-bank move enable (movi2fp / movfp2i).
- xferDir  input  1  0 = integer rs1 -> FP frd; 1 = FP frs1 -> integer rd.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset:
  - On a rising edge with reset=1, every register in both banks loads RESET_VAL, except integer r0, which stays 0.
  - Reset overrides any write in the same cycle, including a reset asserted mid-operation.
- Reads:
  - Purely combinational, zero latency: busA = R[rs1], busB = R[rs2], fbusA = F[frs1], fbusB = F[frs2].
  - Reading integer r0 always returns 0 for any RESET_VAL and any write history.
  - FP f0 is an ordinary register.
- Integer write: on a rising edge with reset=0 and regWr=1, R[rd] <= wrData. A write to rd=0 is discarded.
- FP write: on a rising edge with reset=0 and fregWr=1, F[frd] <= fwrData.
- Cross-bank move: on a rising edge with reset=0 and xferWr=1:
  - xferDir=0: F[frd] <= R[rs1].
  - xferDir=1: R[rd] <= F[frs1]; discarded if rd=0.
  - xferWr has priority over regWr (when xferDir=1) or fregWr (when xferDir=0) targeting the same bank in the same cycle. The other bank's normal write still proceeds.
- Simultaneous events:
  - Integer and FP writes in the same cycle are independent; both commit.
  - Two read ports addressing the same register return identical data.
- Timing without the optional feature: a read of a register being written in the current cycle returns the old value until the edge, and the new value from the cycle after.
- No X propagation: all registers are defined after the first reset edge.
- Sizing: per bank, 2**DEPTH_LOG2 x WIDTH flops. No handshake; every write completes in one cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass on every read port.
  - If a port's specifier matches an enabled write target in the same cycle, the port returns the pending write data combinationally, not the stored value.
  - Integer ports match on regWr with rd, or on xferWr with xferDir=1 and rd. FP ports match on fregWr with frd, or on xferWr with xferDir=0 and frd.
  - Source priority follows the write priority above.
  - Integer r0 is never bypassed.
  - Bypass is suppressed while reset=1.
- Undefined: no bypass muxes; reads always show stored contents.

Test Plan:
- Reset with RESET_VAL=32'hDEAD_BEEF -> after the edge, busA with rs1=5 reads DEADBEEF; rs1=0 reads 0; fbusA with frs1=0 reads DEADBEEF.
- regWr=1, rd=7, wrData=32'h1234_5678, rs1=7 -> busA shows the old value in the write cycle and 12345678 the next cycle. With REGFILE_BYPASS_EN, busA shows 12345678 in the same cycle.
- regWr=1, rd=0, wrData=32'hFFFF_FFFF -> busA with rs1=0 stays 0 before and after the edge, with and without bypass.
- Same cycle: regWr to r3=32'h0000_0011 and fregWr to f3=32'h0000_0022 -> next cycle busB (rs2=3)=11 and fbusB (frs2=3)=22.
- xferWr=1, xferDir=0, rs1=4 (R4=32'h0000_00AA), frd=9, plus fregWr=1, frd=9, fwrData=32'h0000_0055 -> F9=AA; the xfer wins.
- Write and reset asserted together (regWr=1, rd=2, wrData=32'h99) -> R2=RESET_VAL after the edge; during reset, with bypass enabled, busA (rs1=2) does not show 99.
